div_request_sequencer: RTL and testbench

- Front end for the pipelined signed/unsigned divider.
- Accepts divide requests over a valid/ready handshake and assigns 6-bit tags. Drives the divider's input bus and captures the divider's tagged results into a slot buffer.
- Returns results to the requester strictly in issue order, also over valid/ready.
- The divider has no backpressure, so this block bounds outstanding operations to the buffer depth.

---
 rtl/div_request_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_div_request_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_request_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : div_request_sequencer                                      |
// | Description : Front end for the pipelined signed/unsigned divider.       |
// |               Tags and issues requests, captures tagged results into a   |
// |               slot buffer and returns them in issue order.               |
// | Options     : DIV_SEQ_STALL_STATS_EN - enables the stall_count counter   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module div_request_sequencer #(
   parameter int DIVIDEND_WIDTH = 12,
   parameter int DIVISOR_WIDTH  = 6,
   parameter int DEPTH          = 16,
   parameter int DIV_LATENCY    = 14
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [DIVIDEND_WIDTH-1:0] req_dividend,
   input  logic [DIVISOR_WIDTH-1:0]  req_divisor,
   output logic                      div_input_valid,
   output logic [5:0]                div_input_tag,
   output logic [DIVIDEND_WIDTH-1:0] div_dividend,
   output logic [DIVISOR_WIDTH-1:0]  div_divisor,
   input  logic                      div_output_valid,
   input  logic [5:0]                div_output_tag,
   input  logic [DIVIDEND_WIDTH-1:0] div_quotient,
   input  logic [DIVIDEND_WIDTH-1:0] div_remainder,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DIVIDEND_WIDTH-1:0] rsp_quotient,
   output logic [DIVIDEND_WIDTH-1:0] rsp_remainder,
   output logic                      rsp_div_by_zero,
   output logic [6:0]                outstanding,
   output logic                      tag_error,
   output logic [15:0]               stall_count
);

   localparam int                   c_SLOT_W     = $clog2(DEPTH);
   localparam int                   c_FLUSH_W    = $clog2(DIV_LATENCY + 2);
   localparam logic [c_FLUSH_W-1:0] c_FLUSH_INIT = c_FLUSH_W'(DIV_LATENCY + 1);
   localparam logic [c_FLUSH_W-1:0] c_FLUSH_ONE  = c_FLUSH_W'(1);
   localparam logic [6:0]           c_DEPTH_CNT  = 7'(DEPTH);
   localparam logic [0:0]           c_ST_FLUSH   = 1'b0;
   localparam logic [0:0]           c_ST_RUN     = 1'b1;

   logic [0:0]                r_state;
   logic [0:0]                w_state_next;
   logic [c_FLUSH_W-1:0]      r_flush_cnt;
   logic [c_FLUSH_W-1:0]      w_flush_cnt_next;
   logic                      w_run;

   logic [5:0]                r_issue_ptr;
   logic [5:0]                r_retire_ptr;
   logic [6:0]                r_outstanding;
   logic [DEPTH-1:0]          r_filled;
   logic [DEPTH-1:0]          r_dbz;
   logic [DIVIDEND_WIDTH-1:0] r_quot [DEPTH];
   logic [DIVIDEND_WIDTH-1:0] r_rem  [DEPTH];
   logic                      r_tag_error;

   logic                      r_div_valid;
   logic [5:0]                r_div_tag;
   logic [DIVIDEND_WIDTH-1:0] r_div_dividend;
   logic [DIVISOR_WIDTH-1:0]  r_div_divisor;

   logic                      w_issue;
   logic                      w_retire;
   logic                      w_cap;
   logic                      w_cap_ok;
   logic [c_SLOT_W-1:0]       w_issue_slot;
   logic [c_SLOT_W-1:0]       w_rsp_slot;
   logic [c_SLOT_W-1:0]       w_cap_slot;
   logic [5:0]                w_tag_off;

   // State register: flush window counts down after reset to drain stale divider results
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= c_ST_FLUSH;
         r_flush_cnt <= c_FLUSH_INIT;
      end else begin
         r_state     <= w_state_next;
         r_flush_cnt <= w_flush_cnt_next;
      end
   end

   // Next-state logic: leave FLUSH on the cycle the counter reaches zero
   always_comb begin
      w_state_next     = r_state;
      w_flush_cnt_next = r_flush_cnt;
      case (r_state)
         c_ST_FLUSH: begin
            if (r_flush_cnt <= c_FLUSH_ONE) begin
               w_state_next     = c_ST_RUN;
               w_flush_cnt_next = '0;
            end else begin
               w_flush_cnt_next = r_flush_cnt - c_FLUSH_ONE;
            end
         end
         default: w_state_next = c_ST_RUN;
      endcase
   end

   // FSM outputs: accept only in RUN and while a result slot is guaranteed
   always_comb begin
      w_run     = (r_state == c_ST_RUN);
      req_ready = w_run && (r_outstanding < c_DEPTH_CNT);
   end

   assign w_issue_slot = r_issue_ptr[c_SLOT_W-1:0];
   assign w_rsp_slot   = r_retire_ptr[c_SLOT_W-1:0];
   assign w_cap_slot   = div_output_tag[c_SLOT_W-1:0];
   assign w_tag_off    = div_output_tag - r_retire_ptr;
   assign w_issue      = req_valid && req_ready;
   assign w_retire     = rsp_valid && rsp_ready;
   assign w_cap        = div_output_valid && w_run;
   // A retiring slot is still marked filled this cycle, so a same-slot capture is rejected here too
   assign w_cap_ok     = w_cap && ({1'b0, w_tag_off} < r_outstanding) && !r_filled[w_cap_slot];

   // Response view of the head slot; divide-by-zero overrides the divider result
   always_comb begin
      rsp_valid       = r_filled[w_rsp_slot];
      rsp_div_by_zero = r_dbz[w_rsp_slot];
      rsp_quotient    = r_quot[w_rsp_slot];
      rsp_remainder   = r_rem[w_rsp_slot];
      if (r_dbz[w_rsp_slot]) begin
         rsp_quotient  = '1;
         rsp_remainder = '0;
      end
   end

   // Divider input register: one-cycle pulse per issue, data held between issues
   always_ff @(posedge clock) begin
      if (reset) begin
         r_div_valid    <= 1'b0;
         r_div_tag      <= '0;
         r_div_dividend <= '0;
         r_div_divisor  <= '0;
      end else begin
         r_div_valid <= w_issue;
         if (w_issue) begin
            r_div_tag      <= r_issue_ptr;
            r_div_dividend <= req_dividend;
            r_div_divisor  <= req_divisor;
         end
      end
   end

   // Pointers and occupancy count
   always_ff @(posedge clock) begin
      if (reset) begin
         r_issue_ptr   <= '0;
         r_retire_ptr  <= '0;
         r_outstanding <= '0;
      end else begin
         if (w_issue)
            r_issue_ptr <= r_issue_ptr + 6'd1;
         if (w_retire)
            r_retire_ptr <= r_retire_ptr + 6'd1;
         case ({w_issue, w_retire})
            2'b10:   r_outstanding <= r_outstanding + 7'd1;
            2'b01:   r_outstanding <= r_outstanding - 7'd1;
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   // Slot flags: retire clears, capture fills, issue records divide-by-zero
   always_ff @(posedge clock) begin
      if (reset) begin
         r_filled <= '0;
         r_dbz    <= '0;
      end else begin
         if (w_retire) begin
            r_filled[w_rsp_slot] <= 1'b0;
            r_dbz[w_rsp_slot]    <= 1'b0;
         end
         if (w_cap_ok)
            r_filled[w_cap_slot] <= 1'b1;
         if (w_issue)
            r_dbz[w_issue_slot] <= (req_divisor == '0);
      end
   end

   // Slot payload storage; validity is tracked by r_filled so no reset is needed
   always_ff @(posedge clock) begin
      if (w_cap_ok) begin
         r_quot[w_cap_slot] <= div_quotient;
         r_rem[w_cap_slot]  <= div_remainder;
      end
   end

   // Sticky flag for results that were unexpected or collided with a filled slot
   always_ff @(posedge clock) begin
      if (reset)
         r_tag_error <= 1'b0;
      else if (w_cap && !w_cap_ok)
         r_tag_error <= 1'b1;
   end

`ifdef DIV_SEQ_STALL_STATS_EN
   logic [15:0] r_stall_count;

   // Saturating count of RUN cycles where a request was held off
   always_ff @(posedge clock) begin
      if (reset)
         r_stall_count <= '0;
      else if (w_run && req_valid && !req_ready && (r_stall_count != 16'hFFFF))
         r_stall_count <= r_stall_count + 16'd1;
   end

   assign stall_count = r_stall_count;
`else
   assign stall_count = 16'h0000;
`endif

   assign div_input_valid = r_div_valid;
   assign div_input_tag   = r_div_tag;
   assign div_dividend    = r_div_dividend;
   assign div_divisor     = r_div_divisor;
   assign outstanding     = r_outstanding;
   assign tag_error       = r_tag_error;

endmodule
`default_nettype wire

// File: tb/tb_div_request_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_div_request_sequencer                                   |
// | Description : Self-checking bench for div_request_sequencer with a       |
// |               behavioural divider and an in-order scoreboard.            |
// | Options     : DIV_SEQ_STALL_STATS_EN - expects a live stall_count        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_div_request_sequencer;

   localparam int c_DW    = 12;
   localparam int c_VW    = 6;
   localparam int c_DEPTH = 16;
   localparam int c_LAT   = 14;
   localparam int c_FLUSH = c_LAT + 1;   // cycles of req_ready=0 after reset
   localparam int c_RSP   = c_LAT + 3;   // sample-to-visible delay of a result

   typedef struct {
      logic [c_DW-1:0] q;
      logic [c_DW-1:0] r;
      logic            dbz;
      int              at;
   } exp_t;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic [c_DW-1:0] req_dividend = '0;
   logic [c_VW-1:0] req_divisor = '0;
   logic            div_input_valid;
   logic [5:0]      div_input_tag;
   logic [c_DW-1:0] div_dividend;
   logic [c_VW-1:0] div_divisor;
   logic            div_output_valid;
   logic [5:0]      div_output_tag;
   logic [c_DW-1:0] div_quotient;
   logic [c_DW-1:0] div_remainder;
   logic            rsp_valid;
   logic            rsp_ready = 1'b0;
   logic [c_DW-1:0] rsp_quotient;
   logic [c_DW-1:0] rsp_remainder;
   logic            rsp_div_by_zero;
   logic [6:0]      outstanding;
   logic            tag_error;
   logic [15:0]     stall_count;

   logic            inj_v = 1'b0;
   logic [5:0]      inj_t = '0;

   int   cyc = 0;
   int   base = 0;
   int   issued = 0;
   int   stall_m = 0;
   bit   exp_tag_err = 1'b0;
   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   div_request_sequencer #(
      .DIVIDEND_WIDTH(c_DW),
      .DIVISOR_WIDTH (c_VW),
      .DEPTH         (c_DEPTH),
      .DIV_LATENCY   (c_LAT)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_dividend    (req_dividend),
      .req_divisor     (req_divisor),
      .div_input_valid (div_input_valid),
      .div_input_tag   (div_input_tag),
      .div_dividend    (div_dividend),
      .div_divisor     (div_divisor),
      .div_output_valid(div_output_valid),
      .div_output_tag  (div_output_tag),
      .div_quotient    (div_quotient),
      .div_remainder   (div_remainder),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_quotient    (rsp_quotient),
      .rsp_remainder   (rsp_remainder),
      .rsp_div_by_zero (rsp_div_by_zero),
      .outstanding     (outstanding),
      .tag_error       (tag_error),
      .stall_count     (stall_count)
   );

   // Signed dividend / unsigned divisor, truncating toward zero
   function automatic logic [2*c_DW-1:0] ref_div(input logic [c_DW-1:0] a, input logic [c_VW-1:0] b);
      int sa, sbv, q, r;
      sa  = int'($signed(a));
      sbv = int'(b);
      if (sbv == 0) begin
         q = -1;
         r = sa;
      end else begin
         q = sa / sbv;
         r = sa % sbv;
      end
      return {q[c_DW-1:0], r[c_DW-1:0]};
   endfunction

   // Behavioural reset-less divider: result appears c_LAT cycles after the sampling edge
   logic [c_LAT:0]  pv = '0;
   logic [5:0]      pt [c_LAT+1];
   logic [c_DW-1:0] pq [c_LAT+1];
   logic [c_DW-1:0] pr [c_LAT+1];

   always @(posedge clock) begin
      pv    <= {pv[c_LAT-1:0], div_input_valid};
      pt[0] <= div_input_tag;
      {pq[0], pr[0]} <= ref_div(div_dividend, div_divisor);
      for (int i = 1; i <= c_LAT; i++) begin
         pt[i] <= pt[i-1];
         pq[i] <= pq[i-1];
         pr[i] <= pr[i-1];
      end
   end

   assign div_output_valid = pv[c_LAT] | inj_v;
   assign div_output_tag   = inj_v ? inj_t : pt[c_LAT];
   assign div_quotient     = pq[c_LAT];
   assign div_remainder    = pr[c_LAT];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      inj_v     = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      sb.delete();
      base        = cyc;
      issued      = 0;
      stall_m     = 0;
      exp_tag_err = 1'b0;
   endtask

   // One clock: check outputs against the model, advance model, check issue bus
   task automatic tick(output bit acc);
      bit              run, exp_ready, exp_rv, ret;
      logic [c_DW-1:0] d;
      logic [c_VW-1:0] v;
      exp_t            e;
      run       = (cyc - base) >= c_FLUSH;
      exp_ready = run && (sb.size() < c_DEPTH);
      exp_rv    = (sb.size() > 0) && (cyc >= sb[0].at);
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("outstanding", 32'(outstanding), sb.size());
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("tag_error", 32'(tag_error), 32'(exp_tag_err));
      if (exp_rv) begin
         chk("rsp_quotient", 32'(rsp_quotient), 32'(sb[0].q));
         chk("rsp_remainder", 32'(rsp_remainder), 32'(sb[0].r));
         chk("rsp_div_by_zero", 32'(rsp_div_by_zero), 32'(sb[0].dbz));
      end
`ifdef DIV_SEQ_STALL_STATS_EN
      chk("stall_count", 32'(stall_count), stall_m);
`else
      chk("stall_count", 32'(stall_count), 0);
`endif
      if (run && req_valid && !exp_ready) stall_m++;
      acc = req_valid && exp_ready;
      ret = exp_rv && rsp_ready;
      d   = req_dividend;
      v   = req_divisor;
      if (ret) void'(sb.pop_front());
      if (acc) begin
         e.at = cyc + c_RSP;
         if (v == '0) begin
            e.q   = '1;
            e.r   = '0;
            e.dbz = 1'b1;
         end else begin
            {e.q, e.r} = ref_div(d, v);
            e.dbz      = 1'b0;
         end
         sb.push_back(e);
      end
      @(posedge clock);
      @(negedge clock);
      chk("div_input_valid", 32'(div_input_valid), 32'(acc));
      if (acc) begin
         chk("div_input_tag", 32'(div_input_tag), issued % 64);
         chk("div_dividend", 32'(div_dividend), 32'(d));
         chk("div_divisor", 32'(div_divisor), 32'(v));
         issued++;
      end
   endtask

   task automatic drain();
      bit a;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 200 && sb.size() > 0; i++) tick(a);
      chk("drain_left", sb.size(), 0);
   endtask

   initial begin
      bit a;
      int n_acc;
      int idx;

      // Reset state
      do_reset();
      chk("rst_div_input_valid", 32'(div_input_valid), 0);
      chk("rst_div_input_tag", 32'(div_input_tag), 0);
      chk("rst_div_dividend", 32'(div_dividend), 0);
      chk("rst_div_divisor", 32'(div_divisor), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_outstanding", 32'(outstanding), 0);
      chk("rst_tag_error", 32'(tag_error), 0);
      chk("rst_stall_count", 32'(stall_count), 0);

      // Flush window with req_valid held and junk divider results injected
      req_valid    = 1'b1;
      req_dividend = 12'd100;
      req_divisor  = 6'd7;
      rsp_ready    = 1'b1;
      for (int i = 0; i < c_FLUSH; i++) begin
         inj_v = (i >= 3 && i < 7);
         inj_t = 6'd5;
         chk("flush_ready", 32'(req_ready), 0);
         tick(a);
      end
      inj_v = 1'b0;
      chk("flush_end_ready", 32'(req_ready), 1);
      chk("flush_tag_error", 32'(tag_error), 0);

      // Single request 100/7, first tag 0, result 16 cycles later
      tick(a);
      req_valid = 1'b0;
      chk("single_acc", 32'(a), 1);
      chk("single_tag", 32'(div_input_tag), 0);
      repeat (15) tick(a);
      chk("single_early", 32'(rsp_valid), 0);
      tick(a);
      chk("single_valid", 32'(rsp_valid), 1);
      chk("single_q", 32'(rsp_quotient), 14);
      chk("single_r", 32'(rsp_remainder), 2);
      drain();

      // Fill to depth with rsp_ready low
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      n_acc = 0;
      for (int i = 0; i < 24; i++) begin
         req_dividend = 12'($urandom);
         req_divisor  = 6'($urandom_range(1, 63));
         tick(a);
         n_acc += int'(a);
      end
      chk("full_accepts", n_acc, 16);
      chk("full_outstanding", 32'(outstanding), 16);
      chk("full_ready", 32'(req_ready), 0);
      rsp_ready = 1'b1;
      tick(a);
      rsp_ready = 1'b0;
      chk("full_after_ret_out", 32'(outstanding), 15);
      chk("full_after_ret_ready", 32'(req_ready), 1);
      tick(a);
      chk("full_refill_acc", 32'(a), 1);
      chk("full_refill_out", 32'(outstanding), 16);
`ifdef DIV_SEQ_STALL_STATS_EN
      chk("full_stall_count", 32'(stall_count), stall_m);
`endif
      drain();

      // Divide-by-zero between two normal requests
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_dividend = 12'd50; req_divisor = 6'd5; tick(a);
      req_dividend = 12'd77; req_divisor = 6'd0; tick(a);
      req_dividend = 12'd9;  req_divisor = 6'd3; tick(a);
      req_valid = 1'b0;
      repeat (20) tick(a);
      chk("dbz_first_q", 32'(rsp_quotient), 10);
      chk("dbz_first_flag", 32'(rsp_div_by_zero), 0);
      rsp_ready = 1'b1;
      tick(a);
      chk("dbz_mid_q", 32'(rsp_quotient), 32'hFFF);
      chk("dbz_mid_r", 32'(rsp_remainder), 0);
      chk("dbz_mid_flag", 32'(rsp_div_by_zero), 1);
      tick(a);
      chk("dbz_last_q", 32'(rsp_quotient), 3);
      drain();

      // 70 consecutive requests i/1 across the tag wrap
      do_reset();
      repeat (c_FLUSH) tick(a);
      rsp_ready = 1'b1;
      req_divisor = 6'd1;
      idx = 0;
      for (int i = 0; i < 600 && idx < 70; i++) begin
         req_valid    = 1'b1;
         req_dividend = 12'(idx);
         tick(a);
         idx += int'(a);
      end
      chk("wrap_accepted", idx, 70);
      drain();
      chk("wrap_tag_error", 32'(tag_error), 0);

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         req_valid    = 1'($urandom_range(0, 1));
         rsp_ready    = ($urandom_range(0, 3) != 0);
         req_dividend = 12'($urandom);
         req_divisor  = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
         tick(a);
      end
      drain();

      // Reset mid-operation: in-flight work vanishes silently
      req_valid = 1'b1;
      rsp_ready = 1'b0;
      repeat (5) tick(a);
      do_reset();
      repeat (40) tick(a);
      chk("midrst_rsp_valid", 32'(rsp_valid), 0);
      chk("midrst_tag_error", 32'(tag_error), 0);

      // Unissued tag raises a sticky error cleared only by reset
      inj_v = 1'b1;
      inj_t = 6'd37;
      tick(a);
      inj_v = 1'b0;
      exp_tag_err = 1'b1;
      repeat (5) tick(a);
      chk("tagerr_sticky", 32'(tag_error), 1);
      do_reset();
      tick(a);
      chk("tagerr_cleared", 32'(tag_error), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute time bound
   initial begin
      #2000000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
